// File: rtl/pipe_pkg.sv
// pipe_pkg: control-bundle field offsets and size helpers shared by the decode/execute stage.
package pipe_pkg;
  localparam int MEM_WRITE_BIT   = 0;
  localparam int BNEQ_BIT        = 1;
  localparam int BEQ_BIT         = 2;
  localparam int MEM_REG_SEL_BIT = 3;
  localparam int WR_EN_BIT       = 4;
  localparam int SHIFT_LSB       = 5;
  localparam int ALU_CTRL_LSB    = 10;
  function automatic int num_threads(input int thread_bits);
    return 1 << thread_bits;
  endfunction
  function automatic int payload_width(input int dw, input int ra, input int ia, input int cw);
    return 2 * ia + 3 * dw + ra + cw;
  endfunction
endpackage

// File: rtl/pipe_skid_flush.sv
// pipe_skid_flush: 2-entry in-order skid buffer with per-tag flush and per-cycle drop count.
module pipe_skid_flush
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 8,
  parameter int THREAD_BITS   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]             in_data,
  input  logic [THREAD_BITS-1:0]               in_tag,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [PAYLOAD_WIDTH-1:0]             out_data,
  output logic [THREAD_BITS-1:0]               out_tag,
  input  logic                                 flush_en,
  input  logic [num_threads(THREAD_BITS)-1:0]  flush_mask,
  output logic [1:0]                           drop
);
  logic                     a_valid, b_valid;
  logic [PAYLOAD_WIDTH-1:0] a_data, b_data;
  logic [THREAD_BITS-1:0]   a_tag, b_tag;
  logic kill_a, kill_b, kill_in, in_fire, keep_a, keep_b, keep_in;
  always_comb begin
    kill_a    = a_valid & flush_en & flush_mask[a_tag];
    kill_b    = b_valid & flush_en & flush_mask[b_tag];
    in_ready  = !b_valid;
    in_fire   = in_valid & in_ready;
    kill_in   = in_fire & flush_en & flush_mask[in_tag];
    out_valid = a_valid & !kill_a;
    keep_a    = out_valid & !out_ready;
    keep_b    = b_valid & !kill_b;
    keep_in   = in_fire & !kill_in;
    out_data  = a_data;
    out_tag   = a_tag;
    drop      = {1'b0, kill_a} + {1'b0, kill_b} + {1'b0, kill_in};
  end
  // B is only ever occupied while A is, so B valid implies no incoming beat this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      a_data  <= '0;
      b_data  <= '0;
      a_tag   <= '0;
      b_tag   <= '0;
    end else begin
      a_valid <= keep_a | keep_b | keep_in;
      b_valid <= keep_a & (keep_b | keep_in);
      if (!keep_a && keep_b) begin
        a_data <= b_data;
        a_tag  <= b_tag;
      end else if (!keep_a && keep_in) begin
        a_data <= in_data;
        a_tag  <= in_tag;
      end
      if (keep_a && !keep_b && keep_in) begin
        b_data <= in_data;
        b_tag  <= in_tag;
      end
    end
  end
endmodule

// File: rtl/pipe_decode_execute_skid.sv
// pipe_decode_execute_skid: decode/execute stage with valid/ready skid buffer, per-thread flush,
// bubble-safe control gating and a saturating flush-drop counter.
module pipe_decode_execute_skid
  import pipe_pkg::*;
#(
  parameter int DATAPATH_WIDTH     = 64,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int INST_ADDR_WIDTH    = 9,
  parameter int THREAD_BITS        = 2,
  parameter int CTRL_WIDTH         = 14,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [INST_ADDR_WIDTH-1:0]          pc_in,
  input  logic [DATAPATH_WIDTH-1:0]           R1_data_in,
  input  logic [DATAPATH_WIDTH-1:0]           R2_data_in,
  input  logic [DATAPATH_WIDTH-1:0]           store_data_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0]       WR_addr_in,
  input  logic [CTRL_WIDTH-1:0]               ctrl_in,
  input  logic [INST_ADDR_WIDTH-1:0]          branch_offset_in,
  input  logic [THREAD_BITS-1:0]              thread_id_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [INST_ADDR_WIDTH-1:0]          pc_out,
  output logic [DATAPATH_WIDTH-1:0]           R1_data_out,
  output logic [DATAPATH_WIDTH-1:0]           R2_data_out,
  output logic [DATAPATH_WIDTH-1:0]           store_data_out,
  output logic [REGFILE_ADDR_WIDTH-1:0]       WR_addr_out,
  output logic [CTRL_WIDTH-1:0]               ctrl_out,
  output logic [INST_ADDR_WIDTH-1:0]          branch_offset_out,
  output logic [THREAD_BITS-1:0]              thread_id_out,
  input  logic                                flush_en,
  input  logic [num_threads(THREAD_BITS)-1:0] flush_mask,
  output logic [CNT_WIDTH-1:0]                drop_count
);
  localparam int PW = payload_width(DATAPATH_WIDTH, REGFILE_ADDR_WIDTH, INST_ADDR_WIDTH, CTRL_WIDTH);
  // Bits that would cause architectural side effects if a bubble leaked into execute.
  localparam logic [CTRL_WIDTH-1:0] GATE = (CTRL_WIDTH'(1) << WR_EN_BIT) | (CTRL_WIDTH'(1) << MEM_WRITE_BIT)
                                         | (CTRL_WIDTH'(1) << BEQ_BIT) | (CTRL_WIDTH'(1) << BNEQ_BIT);
  logic [PW-1:0]         in_data, out_data;
  logic [CTRL_WIDTH-1:0] ctrl_a;
  logic [1:0]            drop;
  logic [CNT_WIDTH:0]    drop_sum;
  assign in_data = {pc_in, R1_data_in, R2_data_in, store_data_in, WR_addr_in, ctrl_in, branch_offset_in};
  assign {pc_out, R1_data_out, R2_data_out, store_data_out, WR_addr_out, ctrl_a, branch_offset_out} = out_data;
  assign ctrl_out = out_valid ? ctrl_a : ctrl_a & ~GATE;
  assign drop_sum = {1'b0, drop_count} + (CNT_WIDTH + 1)'(drop);
  pipe_skid_flush #(.PAYLOAD_WIDTH(PW), .THREAD_BITS(THREAD_BITS)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (thread_id_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (thread_id_out),
    .flush_en  (flush_en),
    .flush_mask(flush_mask),
    .drop      (drop)
  );
  always_ff @(posedge clk) begin
    if (reset) drop_count <= '0;
    else drop_count <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
  end
endmodule

// File: tb/tb_pipe_decode_execute_skid.sv
// tb_pipe_decode_execute_skid: directed and random stimulus checked against a queue-based model.
module tb_pipe_decode_execute_skid;
  import pipe_pkg::*;
  localparam int DW = 64, RA = 5, IA = 9, TB = 2, NT = 4, CW = 14, CN = 16;
  typedef struct packed {
    logic [IA-1:0] pc;
    logic [DW-1:0] r1, r2, st;
    logic [RA-1:0] wa;
    logic [CW-1:0] ctrl;
    logic [IA-1:0] off;
    logic [TB-1:0] tid;
  } beat_t;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, flush_en = 0;
  logic [NT-1:0] flush_mask = '0;
  beat_t in_b = '0;
  logic in_ready, out_valid;
  logic [IA-1:0] pc_out, branch_offset_out;
  logic [DW-1:0] R1_data_out, R2_data_out, store_data_out;
  logic [RA-1:0] WR_addr_out;
  logic [CW-1:0] ctrl_out;
  logic [TB-1:0] thread_id_out;
  logic [CN-1:0] drop_count;
  logic [CW-1:0] gate_bits;
  beat_t q[$];
  int unsigned exp_drops = 0;
  int errors = 0, checks = 0;
  bit fired;
  int idx;
  always #5 clk = ~clk;
  pipe_decode_execute_skid dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(in_b.pc), .R1_data_in(in_b.r1), .R2_data_in(in_b.r2), .store_data_in(in_b.st),
    .WR_addr_in(in_b.wa), .ctrl_in(in_b.ctrl), .branch_offset_in(in_b.off), .thread_id_in(in_b.tid),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .R1_data_out(R1_data_out),
    .R2_data_out(R2_data_out), .store_data_out(store_data_out), .WR_addr_out(WR_addr_out),
    .ctrl_out(ctrl_out), .branch_offset_out(branch_offset_out), .thread_id_out(thread_id_out),
    .flush_en(flush_en), .flush_mask(flush_mask), .drop_count(drop_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic rand_beat(input logic [IA-1:0] pc, input logic [TB-1:0] tid);
    in_b.pc = pc;
    in_b.r1 = {$urandom, $urandom};
    in_b.r2 = {$urandom, $urandom};
    in_b.st = {$urandom, $urandom};
    in_b.wa = RA'($urandom);
    in_b.ctrl = CW'($urandom);
    in_b.off = IA'($urandom);
    in_b.tid = tid;
  endtask
  function automatic bit killed(input beat_t b);
    return flush_en && flush_mask[b.tid];
  endfunction
  // Called with inputs settled just after a falling edge; checks, advances the model, then
  // moves to the next falling edge.
  task automatic step();
    beat_t nq[$];
    bit ov;
    int d = 0;
    #1;
    ov = q.size() > 0 && !killed(q[0]);
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(ov));
    if (ov) begin
      check("pc_out", 64'(pc_out), 64'(q[0].pc));
      check("r1", R1_data_out, q[0].r1);
      check("r2", R2_data_out, q[0].r2);
      check("store", store_data_out, q[0].st);
      check("wr_addr", 64'(WR_addr_out), 64'(q[0].wa));
      check("ctrl", 64'(ctrl_out), 64'(q[0].ctrl));
      check("offset", 64'(branch_offset_out), 64'(q[0].off));
      check("tid", 64'(thread_id_out), 64'(q[0].tid));
    end else begin
      check("ctrl_gated", 64'(ctrl_out & gate_bits), 64'd0);
    end
    check("drop_count", 64'(drop_count), 64'(exp_drops));
    fired = in_valid && q.size() < 2;
    if (reset) begin
      q.delete();
      exp_drops = 0;
    end else begin
      foreach (q[i]) begin
        if (killed(q[i])) d++;
        else if (!(i == 0 && out_ready)) nq.push_back(q[i]);
      end
      if (fired) begin
        if (killed(in_b)) d++;
        else nq.push_back(in_b);
      end
      exp_drops = (exp_drops + d > 65535) ? 65535 : exp_drops + d;
      q = nq;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    gate_bits = '0;
    gate_bits[WR_EN_BIT] = 1'b1;
    gate_bits[MEM_WRITE_BIT] = 1'b1;
    gate_bits[BEQ_BIT] = 1'b1;
    gate_bits[BNEQ_BIT] = 1'b1;
    @(negedge clk);
    repeat (2) step();
    reset = 0;
    // reset state
    step();
    // streaming with out_ready high
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      rand_beat(IA'(i), TB'($urandom));
      step();
      check("stream_accept", 64'(fired), 64'd1);
    end
    in_valid = 0;
    step();
    check("stream_drop", 64'(drop_count), 64'd0);
    // stall: third beat must be held by decode
    out_ready = 0;
    in_valid = 1;
    idx = 0;
    rand_beat(IA'(9'h10), 2'd0);
    repeat (4) begin
      step();
      if (fired) begin
        idx++;
        rand_beat(IA'(9'h10 + idx), 2'd0);
      end
    end
    check("stall_accepts", 64'(idx), 64'd2);
    out_ready = 1;
    for (int k = 0; k < 10 && idx < 3; k++) begin
      step();
      if (fired) idx++;
    end
    check("stall_resume", 64'(idx), 64'd3);
    in_valid = 0;
    repeat (3) step();
    // per-thread flush of the head only
    out_ready = 0;
    in_valid = 1;
    rand_beat(9'h20, 2'd1);
    step();
    rand_beat(9'h21, 2'd2);
    step();
    in_valid = 0;
    flush_en = 1;
    flush_mask = 4'b0010;
    step();
    flush_en = 0;
    step();
    check("flush_head_tid", 64'(thread_id_out), 64'd2);
    check("flush_drop", 64'(drop_count), 64'd1);
    out_ready = 1;
    repeat (2) step();
    // killed incoming beat into empty stage
    in_valid = 1;
    rand_beat(9'h30, 2'd3);
    flush_en = 1;
    flush_mask = 4'b1000;
    step();
    in_valid = 0;
    flush_en = 0;
    step();
    check("kill_in_empty", 64'(out_valid), 64'd0);
    // bubble gating with side-effect bits on the inputs
    in_b.ctrl = '1;
    step();
    // reset overrides flush and handshake
    out_ready = 0;
    in_valid = 1;
    rand_beat(9'h40, 2'd0);
    step();
    rand_beat(9'h41, 2'd1);
    step();
    reset = 1;
    flush_en = 1;
    flush_mask = '1;
    step();
    reset = 0;
    flush_en = 0;
    in_valid = 0;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    // random traffic
    for (int k = 0; k < 2000; k++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush_en = ($urandom_range(0, 99) < 15);
      flush_mask = NT'($urandom);
      rand_beat(IA'($urandom), TB'($urandom));
      step();
    end
    // saturate the drop counter
    in_valid = 1;
    out_ready = 0;
    flush_en = 1;
    flush_mask = '1;
    while (exp_drops < 16'hFFFE) step();
    flush_en = 0;
    out_ready = 0;
    for (int k = 0; k < 4 && q.size() < 2; k++) step();
    in_valid = 0;
    check("sat_pre", 64'(drop_count), 64'hFFFE);
    flush_en = 1;
    step();
    in_valid = 1;
    repeat (3) step();
    flush_en = 0;
    in_valid = 0;
    step();
    check("sat_hold", 64'(drop_count), 64'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
